// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-size encodings, FSM states and timeout default for the data-memory controller
package dmem_pkg;
  localparam int TIMEOUT_DEF = 255;
  localparam logic [2:0] DT_W  = 3'b000;
  localparam logic [2:0] DT_H  = 3'b001;
  localparam logic [2:0] DT_HU = 3'b010;
  localparam logic [2:0] DT_B  = 3'b011;
  localparam logic [2:0] DT_BU = 3'b100;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  function automatic logic is_half(input logic [2:0] t);
    return t == DT_H || t == DT_HU;
  endfunction
  function automatic logic is_byte(input logic [2:0] t);
    return t == DT_B || t == DT_BU;
  endfunction
endpackage

// File: rtl/dmem_align.sv
// dmem_align: store lane replication/byte enables and load lane extraction with sign/zero extension
module dmem_align
  import dmem_pkg::*;
(
  input  logic [2:0]  i_st_type,
  input  logic [1:0]  i_st_off,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  input  logic [2:0]  i_ld_type,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [7:0]  w_b;
  logic [15:0] w_h;
  // pick the addressed lane and extend it; unknown size codes behave as word
  always_comb begin
    w_b = i_rword[{i_ld_off, 3'b000} +: 8];
    w_h = i_ld_off[1] ? i_rword[31:16] : i_rword[15:0];
    o_rdata = is_byte(i_ld_type) ? {{24{w_b[7] & (i_ld_type == DT_B)}}, w_b} :
              is_half(i_ld_type) ? {{16{w_h[15] & (i_ld_type == DT_H)}}, w_h} : i_rword;
    o_be = !i_we ? 4'hf :
           is_byte(i_st_type) ? 4'b0001 << i_st_off :
           is_half(i_st_type) ? (i_st_off[1] ? 4'b1100 : 4'b0011) : 4'hf;
    o_wdata = is_byte(i_st_type) ? {4{i_wdata[7:0]}} :
              is_half(i_st_type) ? {2{i_wdata[15:0]}} : i_wdata;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data memory controller with stall, misalign detection and ack timeout
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  dm_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_type;
  logic [1:0]    r_off;
  logic          w_pend, w_start, w_tmo, w_fin;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_ld;

  assign w_pend   = mem_rd | mem_wr;
  assign misalign = w_pend & (is_half(dm_type) ? addr[0] : !is_byte(dm_type) && addr[1:0] != 2'b00);
  assign dm_req   = r_state == S_REQ;

  dmem_align u_align (
    .i_st_type (dm_type),
    .i_st_off  (addr[1:0]),
    .i_we      (mem_wr),
    .i_wdata   (wdata),
    .i_ld_type (r_type),
    .i_ld_off  (r_off),
    .i_rword   (dm_rdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .o_rdata   (w_ld)
  );

  // next state, completion and stall; a store wins when both flags are set because mem_wr drives the write flag
  always_comb begin
    w_start = r_state == S_IDLE && w_pend && !misalign;
    w_tmo   = r_state == S_REQ && !dm_ack && r_cnt == CW'(TIMEOUT - 1);
    w_fin   = r_state == S_REQ && (dm_ack || w_tmo);
    w_next  = w_start ? S_REQ : w_fin ? S_DONE : r_state == S_DONE ? S_IDLE : r_state;
    stall   = w_start || r_state == S_REQ;
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // request capture, wait counter, error pulse and load result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_type   <= '0;
      r_off    <= '0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_be    <= '0;
      dm_wdata <= '0;
      rdata    <= '0;
      bus_err  <= 1'b0;
    end else begin
      r_cnt   <= r_state == S_REQ ? r_cnt + 1'b1 : '0;
      bus_err <= w_tmo;
      if (w_start) begin
        r_type   <= dm_type;
        r_off    <= addr[1:0];
        dm_we    <= mem_wr;
        dm_addr  <= {addr[31:2], 2'b00};
        dm_be    <= w_be;
        dm_wdata <= w_wdata;
      end
      if (w_fin && !dm_we) rdata <= w_tmo ? '0 : w_ld;
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed scoreboard bench for dmem_ctrl
module tb_dmem_ctrl;
  import dmem_pkg::*;
  logic        clk = 0, rst = 1, mem_rd = 0, mem_wr = 0, dm_ack = 0;
  logic [2:0]  dm_type = 0;
  logic [31:0] addr = 0, wdata = 0, dm_rdata = 0;
  logic [31:0] rdata, dm_addr, dm_wdata;
  logic        stall, misalign, bus_err, dm_req, dm_we;
  logic [3:0]  dm_be;
  int          checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  int          stalls, req_cycles;
  logic        saw_req, saw_mis, err_done, s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata;

  dmem_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .dm_type(dm_type),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misalign(misalign),
    .bus_err(bus_err), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] m, input int ack_at);
    logic done;
    done = 0;
    mem_rd = rd; mem_wr = wr; dm_type = t; addr = a; wdata = wd; dm_rdata = m;
    #1;
    stalls = 0; req_cycles = 0; saw_req = 0; saw_mis = misalign; err_done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (stall) stalls++;
      if (dm_req) begin
        mem_rd = 0; mem_wr = 0; saw_req = 1;
        s_be = dm_be; s_addr = dm_addr; s_wdata = dm_wdata; s_we = dm_we;
        dm_ack = (req_cycles == ack_at);
        req_cycles++;
      end
      if (!stall && !dm_req) begin
        done = 1; err_done = bus_err; dm_ack = 0; mem_rd = 0; mem_wr = 0;
      end else tick;
    end
    chk("access_bound", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tick; tick;
    chk("rst_dm_req", dm_req, 0);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_dm_be", dm_be, 0);
    chk("rst_dm_addr", dm_addr, 0);
    chk("rst_dm_wdata", dm_wdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stall", stall, 0);
    rst = 0;
    tick;
    // lb sign-extends the top byte, ack in first REQ cycle
    exp_q.push_back(32'hFFFF_FF80);
    access(1, 0, DT_B, 32'h103, 0, 32'h80FF_FF12, 0);
    chk("lb_rdata", rdata, exp_q.pop_front());
    chk("lb_stall", stalls, 2);
    chk("lb_be", s_be, 4'hf);
    chk("lb_we", s_we, 0);
    chk("lb_addr", s_addr, 32'h100);
    tick;
    // sh upper half, ack on third REQ cycle
    exp_q.push_back(32'hFFFF_FF80);
    access(1'b0, 1'b1, DT_H, 32'h202, 32'h0000_BEEF, 0, 2);
    chk("sh_rdata", rdata, exp_q.pop_front());
    chk("sh_be", s_be, 4'b1100);
    chk("sh_wdata", s_wdata, 32'hBEEF_BEEF);
    chk("sh_addr", s_addr, 32'h200);
    chk("sh_we", s_we, 1);
    chk("sh_stall", stalls, 4);
    tick;
    // misaligned word load issues nothing
    exp_q.push_back(32'hFFFF_FF80);
    access(1, 0, DT_W, 32'h101, 0, 0, 0);
    chk("lw_mis_flag", saw_mis, 1);
    chk("lw_mis_req", saw_req, 0);
    chk("lw_mis_stall", stalls, 0);
    chk("lw_mis_rdata", rdata, exp_q.pop_front());
    tick;
    // lhu never acked: timeout after 4 REQ cycles
    exp_q.push_back(32'h0);
    access(1, 0, DT_HU, 32'h40, 0, 32'h1234_5678, -1);
    chk("tmo_rdata", rdata, exp_q.pop_front());
    chk("tmo_req_cycles", req_cycles, 4);
    chk("tmo_stall", stalls, 5);
    chk("tmo_bus_err", err_done, 1);
    tick;
    chk("tmo_bus_err_pulse", bus_err, 0);
    // sb then lbu with memory echoing the written byte
    exp_q.push_back(32'h0);
    access(1'b0, 1'b1, DT_B, 32'h3, 32'h7, 0, 0);
    chk("sb_rdata", rdata, exp_q.pop_front());
    chk("sb_be", s_be, 4'b1000);
    chk("sb_wdata", s_wdata, 32'h0707_0707);
    tick;
    exp_q.push_back(32'h7);
    access(1, 0, DT_BU, 32'h3, 0, 32'h0700_0000, 0);
    chk("lbu_rdata", rdata, exp_q.pop_front());
    tick;
    // extension and lane variants
    exp_q.push_back(32'hFFFF_8001);
    access(1, 0, DT_H, 32'h2, 0, 32'h8001_1234, 1);
    chk("lh_rdata", rdata, exp_q.pop_front());
    tick;
    exp_q.push_back(32'h0000_8001);
    access(1, 0, DT_HU, 32'h6, 0, 32'h8001_1234, 0);
    chk("lhu_rdata", rdata, exp_q.pop_front());
    tick;
    exp_q.push_back(32'h0000_007F);
    access(1, 0, DT_B, 32'h8, 0, 32'hAABB_CC7F, 0);
    chk("lb0_rdata", rdata, exp_q.pop_front());
    tick;
    exp_q.push_back(32'hDEAD_BEEF);
    access(1, 0, 3'b101, 32'hC, 0, 32'hDEAD_BEEF, 0);
    chk("t101_rdata", rdata, exp_q.pop_front());
    chk("t101_be", s_be, 4'hf);
    tick;
    // rd and wr together is a store
    exp_q.push_back(32'hDEAD_BEEF);
    access(1, 1, DT_W, 32'h10, 32'h1234_5678, 32'h5555_5555, 0);
    chk("rdwr_rdata", rdata, exp_q.pop_front());
    chk("rdwr_we", s_we, 1);
    chk("rdwr_wdata", s_wdata, 32'h1234_5678);
    tick;
    // misaligned half
    access(1, 0, DT_H, 32'h41, 0, 0, 0);
    chk("lh_mis_flag", saw_mis, 1);
    chk("lh_mis_req", saw_req, 0);
    tick;
    // ack while idle is ignored
    dm_ack = 1; dm_rdata = 32'h1111_1111;
    tick;
    dm_ack = 0;
    chk("idle_ack_req", dm_req, 0);
    chk("idle_ack_rdata", rdata, 32'hDEAD_BEEF);
    // reset aborts in-flight REQ, late ack ignored
    mem_rd = 1; dm_type = DT_W; addr = 32'h20;
    tick;
    mem_rd = 0;
    chk("abort_in_req", dm_req, 1);
    rst = 1;
    tick;
    rst = 0;
    chk("abort_req", dm_req, 0);
    chk("abort_rdata", rdata, 0);
    dm_ack = 1; dm_rdata = 32'hAAAA_5555;
    tick;
    dm_ack = 0;
    chk("late_ack_req", dm_req, 0);
    chk("late_ack_stall", stall, 0);
    chk("late_ack_bus_err", bus_err, 0);
    tick;
    chk("late_ack_rdata", rdata, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum cycles waited in REQ for dm_ack before error completion.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous, active-high.
REQ-004 mem_rd  input  1  SHALL flag a load in the MEM stage.
REQ-005 mem_wr  input  1  SHALL flag a store in the MEM stage.
REQ-006 dm_type  input  3  SHALL give the access size: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
REQ-007 addr  input  32  SHALL give the byte address.
REQ-008 wdata  input  32  SHALL give the store data, right-aligned.
REQ-009 rdata  output  32  SHALL give the extended load result.
REQ-010 stall  output  1  SHALL freeze the pipeline while the access is outstanding.
REQ-011 misalign  output  1  SHALL flag a misaligned access, combinationally.
REQ-012 bus_err  output  1  SHALL pulse for one cycle on a timeout completion.
REQ-013 dm_req  output  1  SHALL request a memory transfer.
REQ-014 dm_we  output  1  SHALL mark the request as a write.
REQ-015 dm_addr  output  32  SHALL give the word-aligned address, {addr[31:2],2'b00}.
REQ-016 dm_be  output  4  SHALL give the byte-lane enables.
REQ-017 dm_wdata  output  32  SHALL give the lane-replicated store data.
REQ-018 dm_ack  input  1  SHALL signal memory completion; dm_rdata is valid in the same cycle.
REQ-019 dm_rdata  input  32  SHALL give the memory read word.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ and DONE.
REQ-021 IDLE->REQ SHALL occur when (mem_rd|mem_wr)&~misalign; addr, dm_type, wdata and the write flag are captured on this edge; inputs are ignored outside IDLE.
REQ-022 REQ SHALL hold dm_req=1 with stable dm_we, dm_addr, dm_be and dm_wdata until dm_ack, then go to DONE.
REQ-023 REQ SHALL count cycles; when the count reaches TIMEOUT without dm_ack, it SHALL go to DONE with bus_err=1 for the DONE cycle and rdata=0.
REQ-024 DONE->IDLE SHALL occur unconditionally after 1 cycle.
REQ-025 stall SHALL be 1 in IDLE when an access is pending and not misaligned, 1 throughout REQ, and 0 in DONE; minimum stall is 2 cycles (ack in the first REQ cycle).
REQ-026 If mem_rd and mem_wr are both set, the access SHALL be a store.
REQ-027 misalign SHALL be 1 for a half access with addr[0]=1 or a word access with addr[1:0]!=0; no request is issued, stall=0, and rdata is unchanged.
REQ-028 dm_type values 101-111 SHALL be treated as word.
REQ-029 Store byte enables SHALL be: byte 0001<<addr[1:0], data {4{wdata[7:0]}}; half 0011<<{addr[1],0}, data {2{wdata[15:0]}}; word 1111, data wdata.
REQ-030 Loads SHALL drive dm_be=1111; the lane is selected by the captured addr[1:0] or addr[1] and sign- or zero-extended per dm_type.
REQ-031 rdata SHALL be registered on the REQ->DONE edge of a load and held until the next load completion.
REQ-032 Stores SHALL leave rdata unchanged.
REQ-033 dm_ack outside REQ SHALL be ignored.

Reset
REQ-034 On rst, the next edge SHALL give: state IDLE, counter 0, dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0, rdata=0, bus_err=0.
REQ-035 rst SHALL abort an in-flight REQ; a late dm_ack after reset SHALL be ignored.

Structure
REQ-036 The package dmem_pkg SHALL hold the dm_type encodings, the FSM state enum and the TIMEOUT default.
REQ-037 The sub-module dmem_align SHALL be combinational and implement load extraction and store lane alignment/byte enables.

Verification
REQ-038 lb at addr 0x103, dm_rdata 0x80FF_FF12, ack in first REQ cycle -> rdata 0xFFFF_FF80; stall high exactly 2 cycles.
REQ-039 sh at addr 0x202, wdata 0x0000_BEEF, ack after 3 cycles -> dm_be 1100, dm_wdata 0xBEEF_BEEF, dm_addr 0x200, dm_we 1, stall high 4 cycles.
REQ-040 lw at addr 0x101 -> misalign 1, dm_req never asserted, stall 0.
REQ-041 lhu at addr 0x40, no ack, TIMEOUT=4 -> DONE after 4 REQ cycles, bus_err pulse, rdata 0.
REQ-042 rst asserted during REQ, then dm_ack pulsed in the following IDLE cycle -> dm_req 0 on the next edge, no completion, rdata 0.
REQ-043 Back-to-back sb 0x7 at addr 0x3 then lbu at addr 0x3, with memory echoing the write -> dm_be 1000, then rdata 0x0000_0007.
